// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX path among N packetised byte streams.
// Optional grant-stall watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DBIT-1:0] req_data,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      grant,
  output logic              busy,
  output logic              wr_uart,
  output logic [DBIT-1:0]   w_data,
  input  logic              tx_full,
  output logic              timeout_err
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] last_idx;
  logic          in_grant;
  logic          owner_valid;
  logic          owner_last;
  logic [IW-1:0] cand_idx [N];
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: N must be 2..8 and TIMEOUT >= 1");
  end

  // While granted, last_idx always holds the owner's index.
  assign in_grant    = (state == GRANT);
  assign owner_valid = req_valid[last_idx];
  assign owner_last  = req_last[last_idx];

  assign req_ready = in_grant ? (grant & {N{~tx_full}}) : '0;
  assign wr_uart   = in_grant & owner_valid & ~tx_full;
  assign w_data    = in_grant ? req_data[last_idx*DBIT +: DBIT] : '0;

  // Candidate k is the requester k+1 places after the previous winner.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand_idx[gi] = IW'((int'(last_idx) + gi + 1) % N);
  end

  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = last_idx;
    pick_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      last_idx <= IW'(N - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            grant    <= pick_onehot;
            last_idx <= pick_idx;
            busy     <= 1'b1;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end
        GRANT: begin
          if (wr_uart && owner_last) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          // Only cycles where the owner offers nothing count toward the stall.
          if (wr_uart) begin
            idle_cnt <= '0;
          end else if (!owner_valid) begin
            if (idle_cnt == CW'(TIMEOUT - 1)) begin
              state       <= IDLE;
              grant       <= '0;
              busy        <= 1'b0;
              idle_cnt    <= '0;
              timeout_err <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N=2 instance for packet tests, N=4 instance for rotation.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;

  logic [1:0]  rv, rl, ready, grant;
  logic [15:0] rd;
  logic        full, busy, wr, terr;
  logic [7:0]  wd;

  logic [3:0]  rv4, rl4, ready4, grant4;
  logic [31:0] rd4;
  logic        full4, busy4, wr4, terr4;
  logic [7:0]  wd4;

  logic [7:0]  wq[$];
  logic [7:0]  wq4[$];
  logic [3:0]  gq4[$];
  logic [7:0]  exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_arbiter #(.N(2), .DBIT(8), .TIMEOUT(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv), .req_data(rd), .req_last(rl), .req_ready(ready),
    .grant(grant), .busy(busy), .wr_uart(wr), .w_data(wd),
    .tx_full(full), .timeout_err(terr)
  );

  uart_tx_arbiter #(.N(4), .DBIT(8), .TIMEOUT(16)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv4), .req_data(rd4), .req_last(rl4), .req_ready(ready4),
    .grant(grant4), .busy(busy4), .wr_uart(wr4), .w_data(wd4),
    .tx_full(full4), .timeout_err(terr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture what the UART FIFO would receive.
  always @(posedge clk) begin
    if (wr) wq.push_back(wd);
    if (wr4) begin
      wq4.push_back(wd4);
      gq4.push_back(grant4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_count"}, wq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wq.size()) chk($sformatf("%s_byte%0d", tag, k), wq[k], exp_q[k]);
    end
    wq.delete();
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rv = '0; rl = '0; rd = '0; full = 1'b0;
    rv4 = '0; rl4 = '0; rd4 = '0; full4 = 1'b0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 2'b00);
    chk("rst_wr", wr, 1'b0);
    chk("rst_wdata", wd, 8'h00);
    chk("rst_terr", terr, 1'b0);
    tick; tick;
    reset_n = 1'b1;

    // Single-byte packet from requester 1
    tick; rv = 2'b10; rd[15:8] = 8'hA5; rl = 2'b10; #1;
    chk("t1_pre_grant", grant, 2'b00);
    chk("t1_pre_wr", wr, 1'b0);
    tick; #1;
    chk("t1_grant", grant, 2'b10);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", ready, 2'b10);
    chk("t1_wr", wr, 1'b1);
    chk("t1_wdata", wd, 8'hA5);
    tick; rv = 2'b00; rl = 2'b00; #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_wr", wr, 1'b0);
    chk("t1_idle_wdata", wd, 8'h00);
    exp_q = '{8'hA5};
    chk_bytes("t1_fifo");

    // Two simultaneous 3-byte packets; requester 0 wins (1 just went)
    tick; rv = 2'b11; rd = {8'h44, 8'h11}; rl = 2'b00; #1;
    chk("t2_arb_grant", grant, 2'b00);
    tick; #1;
    chk("t2_grant0", grant, 2'b01);
    chk("t2_ready0", ready, 2'b01);
    chk("t2_b0", wd, 8'h11);
    tick; rd[7:0] = 8'h22; #1;
    chk("t2_b1", wd, 8'h22);
    tick; rd[7:0] = 8'h33; rl[0] = 1'b1; #1;
    chk("t2_b2", wd, 8'h33);
    chk("t2_b2_wr", wr, 1'b1);
    tick; rv[0] = 1'b0; rl[0] = 1'b0; #1;
    chk("t2_gap_grant", grant, 2'b00);
    chk("t2_gap_wr", wr, 1'b0);
    tick; #1;
    chk("t2_grant1", grant, 2'b10);
    chk("t2_b3", wd, 8'h44);
    tick; rd[15:8] = 8'h55; #1;
    chk("t2_b4", wd, 8'h55);
    tick; rd[15:8] = 8'h66; rl[1] = 1'b1; #1;
    chk("t2_b5", wd, 8'h66);
    tick; rv = 2'b00; rl = 2'b00; #1;
    chk("t2_end_grant", grant, 2'b00);
    chk("t2_terr", terr, 1'b0);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    chk_bytes("t2_fifo");

    // tx_full held for 5 cycles mid-packet
    tick; rv = 2'b01; rd[7:0] = 8'h77; rl = 2'b00; #1;
    tick; #1;
    chk("t3_grant", grant, 2'b01);
    chk("t3_b0_wr", wr, 1'b1);
    chk("t3_b0", wd, 8'h77);
    tick; rd[7:0] = 8'h88; full = 1'b1; #1;
    chk("t3_full_wr_c0", wr, 1'b0);
    chk("t3_full_ready_c0", ready, 2'b00);
    for (int i = 1; i < 5; i++) begin
      tick; #1;
      chk($sformatf("t3_full_wr_c%0d", i), wr, 1'b0);
      chk($sformatf("t3_full_grant_c%0d", i), grant, 2'b01);
    end
    tick; full = 1'b0; #1;
    chk("t3_release_wr", wr, 1'b1);
    chk("t3_release_b1", wd, 8'h88);
    chk("t3_release_ready", ready, 2'b01);
    tick; rd[7:0] = 8'h99; rl[0] = 1'b1; #1;
    chk("t3_b2", wd, 8'h99);
    tick; rv = 2'b00; rl = 2'b00; #1;
    chk("t3_end_grant", grant, 2'b00);
    exp_q = '{8'h77, 8'h88, 8'h99};
    chk_bytes("t3_fifo");

    // Reset asserted mid-packet after one of three bytes
    tick; rv = 2'b01; rd[7:0] = 8'hAA; rl = 2'b00; #1;
    tick; #1;
    chk("t4_grant", grant, 2'b01);
    chk("t4_b0", wd, 8'hAA);
    tick; rd[7:0] = 8'hBB; rv = 2'b11; rd[15:8] = 8'hDD; rl = 2'b10; #1;
    chk("t4_owner_kept", grant, 2'b01);
    chk("t4_b1", wd, 8'hBB);
    reset_n = 1'b0; #1;
    chk("t4_rst_grant", grant, 2'b00);
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_wr", wr, 1'b0);
    chk("t4_rst_wdata", wd, 8'h00);
    chk("t4_rst_ready", ready, 2'b00);
    tick; reset_n = 1'b1; rd[7:0] = 8'hAA; rl = 2'b11; #1;
    chk("t4_post_idle", grant, 2'b00);
    tick; #1;
    chk("t4_regrant0", grant, 2'b01);
    chk("t4_regrant_b", wd, 8'hAA);
    tick; rv = 2'b10; rl = 2'b10; #1;
    chk("t4_gap", grant, 2'b00);
    tick; #1;
    chk("t4_grant1", grant, 2'b10);
    chk("t4_b_dd", wd, 8'hDD);
    tick; rv = 2'b00; rl = 2'b00; #1;
    exp_q = '{8'hAA, 8'hAA, 8'hDD};
    chk_bytes("t4_fifo");

    // N=4 rotation with all requesters sending 1-byte packets
    tick; rv4 = 4'hF; rl4 = 4'hF; rd4 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    for (int c = 0; c < 40 && wq4.size() < 8; c++) tick;
    rv4 = 4'h0; rl4 = 4'h0; #1;
    chk("t5_count", wq4.size(), 8);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] eb;
      logic [3:0] eg;
      eb = 8'hC0 + 8'(k % 4);
      eg = 4'b0001 << (k % 4);
      if (k < wq4.size()) begin
        chk($sformatf("t5_byte%0d", k), wq4[k], eb);
        chk($sformatf("t5_grant%0d", k), gq4[k], eg);
      end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Owner stalls after one byte; watchdog revokes after 16 idle cycles
    tick; rv = 2'b01; rd[7:0] = 8'h12; rl = 2'b00; #1;
    tick; #1;
    chk("t6_grant", grant, 2'b01);
    chk("t6_b0", wd, 8'h12);
    tick; rv = 2'b10; rd[15:8] = 8'h34; rl = 2'b10; #1;
    chk("t6_stall_wr", wr, 1'b0);
    chk("t6_stall_terr", terr, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick; #1;
      chk($sformatf("t6_hold%0d_terr", i), terr, 1'b0);
      chk($sformatf("t6_hold%0d_grant", i), grant, 2'b01);
    end
    tick; #1;
    chk("t6_terr_pulse", terr, 1'b1);
    chk("t6_revoked", grant, 2'b00);
    chk("t6_busy", busy, 1'b0);
    tick; #1;
    chk("t6_terr_clear", terr, 1'b0);
    chk("t6_grant1", grant, 2'b10);
    chk("t6_b1", wd, 8'h34);
    tick; rv = 2'b00; rl = 2'b00; #1;
    exp_q = '{8'h12, 8'h34};
    chk_bytes("t6_fifo");
`else
    // Without the watchdog a stalled grant is held until the last byte
    tick; rv = 2'b01; rd[7:0] = 8'h12; rl = 2'b00; #1;
    tick; #1;
    chk("t6_grant", grant, 2'b01);
    tick; rv = 2'b10; rd[15:8] = 8'h34; rl = 2'b10; #1;
    for (int i = 0; i < 20; i++) tick;
    chk("t6_held_grant", grant, 2'b01);
    chk("t6_held_terr", terr, 1'b0);
    chk("t6_held_wr", wr, 1'b0);
    rv = 2'b11; rd[7:0] = 8'h56; rl = 2'b11; #1;
    chk("t6_resume_wr", wr, 1'b1);
    chk("t6_resume_b", wd, 8'h56);
    tick; rv = 2'b10; rl = 2'b10; #1;
    chk("t6_end_grant", grant, 2'b00);
    tick; #1;
    chk("t6_grant1", grant, 2'b10);
    chk("t6_b1", wd, 8'h34);
    tick; rv = 2'b00; rl = 2'b00; #1;
    exp_q = '{8'h12, 8'h56, 8'h34};
    chk_bytes("t6_fifo");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
